// File: rtl/ifetch_axi.sv
// Instruction-fetch stage: holds the PC, issues one AXI4-Lite word read per
// instruction and hands the returned word to decode over valid/ready.
module ifetch_axi #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [31:0]           RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [31:0]           inst_pc,
  output logic                  inst_err,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [2:0]            axi_arprot,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [31:0]             pc_reg, pc_next;
  logic                    drop_reg, drop_next;
  logic                    arvalid_reg, arvalid_next;
  logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic                    inst_valid_reg, inst_valid_next;
  logic [DATA_WIDTH-1:0]   inst_data_reg, inst_data_next;
  logic [31:0]             inst_pc_reg, inst_pc_next;
  logic                    inst_err_reg, inst_err_next;
  logic [31:0]             redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h3;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= RESET_PC;
      drop_reg       <= 1'b0;
      arvalid_reg    <= 1'b0;
      araddr_reg     <= RESET_PC[ADDR_WIDTH+1:2];
      inst_valid_reg <= 1'b0;
      inst_data_reg  <= NOP_INSN;
      inst_pc_reg    <= 32'h0;
      inst_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      drop_reg       <= drop_next;
      arvalid_reg    <= arvalid_next;
      araddr_reg     <= araddr_next;
      inst_valid_reg <= inst_valid_next;
      inst_data_reg  <= inst_data_next;
      inst_pc_reg    <= inst_pc_next;
      inst_err_reg   <= inst_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drop_next       = drop_reg;
    araddr_next     = araddr_reg;
    inst_data_next  = inst_data_reg;
    inst_pc_next    = inst_pc_reg;
    inst_err_next   = inst_err_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_ADDR;
        if (redirect_valid) pc_next = redirect_aligned;
      end
      ST_ADDR: begin
        // The request already on the bus must complete; its reply is dropped later.
        if (axi_arready) state_next = ST_RESP;
        if (redirect_valid) begin
          pc_next   = redirect_aligned;
          drop_next = 1'b1;
        end
      end
      ST_RESP: begin
        if (axi_rvalid) begin
          if (redirect_valid) begin
            pc_next    = redirect_aligned;
            drop_next  = 1'b0;
            state_next = ST_ADDR;
          end else if (drop_reg) begin
            drop_next  = 1'b0;
            state_next = ST_ADDR;
          end else begin
            inst_data_next = axi_rdata;
            inst_pc_next   = pc_reg;
            inst_err_next  = (axi_rresp != 2'b00);
            pc_next        = pc_reg + 32'd4;
            state_next     = ST_OUT;
          end
        end else if (redirect_valid) begin
          pc_next   = redirect_aligned;
          drop_next = 1'b1;
        end
      end
      ST_OUT: begin
        // A redirect cancels the presented instruction even if decode accepts it.
        if (redirect_valid) begin
          pc_next    = redirect_aligned;
          state_next = ST_ADDR;
        end else if (inst_ready) begin
          state_next = ST_ADDR;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    arvalid_next    = (state_next == ST_ADDR);
    inst_valid_next = (state_next == ST_OUT);
    // Address is captured on entry to ADDR so a redirect cannot disturb it mid-request.
    if (state_next == ST_ADDR && state_reg != ST_ADDR)
      araddr_next = pc_next[ADDR_WIDTH+1:2];
  end

  assign axi_arvalid = arvalid_reg;
  assign axi_araddr  = araddr_reg;
  assign axi_arprot  = 3'b100;
  assign axi_rready  = (state_reg == ST_RESP);
  assign inst_valid  = inst_valid_reg;
  assign inst_data   = inst_data_reg;
  assign inst_pc     = inst_pc_reg;
  assign inst_err    = inst_err_reg;

endmodule

// File: tb/tb_ifetch_axi.sv
// Randomized bench for ifetch_axi: a ROM slave with random latency and a
// program-order model of which PC/word decode should receive next.
module tb_ifetch_axi;
  localparam int          AW       = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_err;
  logic [AW-1:0] axi_araddr;
  logic [2:0]    axi_arprot;
  logic          axi_arvalid;
  logic          axi_arready = 1'b0;
  logic [31:0]   axi_rdata = 32'h0;
  logic [1:0]    axi_rresp = 2'b00;
  logic          axi_rvalid = 1'b0;
  logic          axi_rready;

  ifetch_axi #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .RESET_PC(RESET_PC), .NOP_INSN(32'h0000_0013)
  ) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 axi_aclk = ~axi_aclk;

  logic [31:0]   rom  [0:1023];
  bit            errm [0:1023];
  int            n_vec = 0;
  int            n_err = 0;
  bit            pend;
  logic [AW-1:0] paddr;
  int            lat;
  logic [31:0]   exp_pc;
  int            idle;
  bit            first_ar;
  bit            ar_wait, iv_wait;
  logic [AW-1:0] ar_hold;
  logic [31:0]   d_hold, p_hold;
  logic          e_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"},    axi_arvalid, 0);
    chk({tag, "_rready"},     axi_rready,  0);
    chk({tag, "_inst_valid"}, inst_valid,  0);
    chk({tag, "_inst_data"},  inst_data,   32'h0000_0013);
    chk({tag, "_inst_pc"},    inst_pc,     0);
    chk({tag, "_inst_err"},   inst_err,    0);
  endtask

  task automatic restart_model();
    pend = 0; lat = 0; exp_pc = RESET_PC; first_ar = 1;
    ar_wait = 0; iv_wait = 0; idle = 0;
  endtask

  task automatic run(input int ncyc, input bit allow_redir);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge axi_aclk);
      if (ar_wait) begin
        chk("ar_hold_valid", axi_arvalid, 1);
        chk("ar_hold_addr", axi_araddr, ar_hold);
      end
      if (iv_wait) begin
        chk("iv_hold_valid", inst_valid, 1);
        chk("iv_hold_data", inst_data, d_hold);
        chk("iv_hold_pc", inst_pc, p_hold);
        chk("iv_hold_err", inst_err, e_hold);
      end
      chk("arprot", axi_arprot, 3'b100);
      if (pend) chk("ar_while_outstanding", axi_arvalid, 0);

      if (pend && lat == 0) begin
        axi_rvalid = 1'b1;
        axi_rdata  = rom[paddr];
        axi_rresp  = errm[paddr] ? 2'b10 : 2'b00;
      end else begin
        axi_rvalid = 1'b0;
        axi_rdata  = $urandom;
        axi_rresp  = 2'($urandom);
      end
      axi_arready    = !pend && ($urandom_range(0, 2) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = allow_redir && ($urandom_range(0, 24) == 0);
      if (redirect_valid) begin
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else                           redirect_pc = 32'($urandom_range(0, 4095));
      end
      #1;

      if (axi_rvalid && axi_rready) pend = 0;
      else if (pend && lat > 0) lat--;
      if (axi_arvalid && axi_arready) begin
        if (first_ar) begin
          chk("first_araddr", axi_araddr, RESET_PC >> 2);
          first_ar = 0;
        end
        pend  = 1;
        paddr = axi_araddr;
        lat   = $urandom_range(0, 2);
      end

      if (inst_valid && inst_ready && !redirect_valid) begin
        $display("fetch pc=%h data=%h err=%0d", inst_pc, inst_data, inst_err);
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_data", inst_data, rom[exp_pc[11:2]]);
        chk("inst_err", inst_err, 32'(errm[exp_pc[11:2]]));
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;

      ar_wait = axi_arvalid && !axi_arready;
      ar_hold = axi_araddr;
      iv_wait = inst_valid && !inst_ready && !redirect_valid;
      d_hold  = inst_data;
      p_hold  = inst_pc;
      e_hold  = inst_err;
      if (idle > 200) begin
        chk("progress_timeout", 32'(idle), 0);
        idle = 0;
      end
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 1024; i++) begin
      rom[i]  = $urandom;
      errm[i] = ($urandom_range(0, 7) == 0);
    end
    rom[0] = 32'h0050_0093; rom[1] = 32'h0010_0113; rom[2] = 32'h0020_81B3;
    errm[0] = 0; errm[1] = 0; errm[2] = 0; errm[3] = 1;

    restart_model();
    #12;
    check_reset_outputs("por");
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    run(30, 1'b0);
    run(2000, 1'b1);
    chk("first_ar_seen", 32'(first_ar), 0);

    // Drive the fetcher into RESP with no reply, then reset it mid-transaction.
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    axi_rvalid     = 1'b0;
    found          = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge axi_aclk);
      axi_rvalid  = 1'b0;
      axi_arready = 1'b1;
      if (axi_rready) found = 1;
    end
    chk("reach_resp", 32'(found), 1);
    #2 axi_aresetn = 1'b0;
    #1 check_reset_outputs("mid_resp_rst");
    @(negedge axi_aclk);
    axi_arready = 1'b0;
    axi_aresetn = 1'b1;
    restart_model();
    run(400, 1'b1);
    chk("first_ar_seen_after_rst", 32'(first_ar), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
